// File: rtl/rotator_pkg.sv
// Shared encodings for the parameterised ring rotator: rotation direction,
// load handshake states and the prescaler counter width.
package rotator_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        READY = 1'b0,
        BUSY  = 1'b1
    } state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/rot_prescaler.sv
// Divide-by-DIV enable prescaler: tick is high on the enabled cycle that
// completes DIV enabled cycles; clr restarts the count from zero.
module rot_prescaler
    import rotator_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign tick = en && (cnt_reg == TERM);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr || tick) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/param_rotator.sv
// Parameterised ring rotator with prescaled stepping and a load handshake.
// Define PARAM_ROTATOR_BOUNCE_EN to add the bounce input (direction reverses at the ends).
module param_rotator
    import rotator_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               DIV   = 1,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
`ifdef PARAM_ROTATOR_BOUNCE_EN
    input  logic             bounce,
`endif
    output logic             load_ready,
    output logic [WIDTH-1:0] out,
    output logic             step
);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    dir_e             dir_reg, dir_next;
    logic             step_reg, step_next;

    logic             tick;
    logic             load_accept;
    logic             rot_en;
    dir_e             eff_dir;
    logic [WIDTH-1:0] rot_left;
    logic [WIDTH-1:0] rot_right;

    assign load_ready  = (state_reg == READY) && !rst;
    assign load_accept = load_valid && load_ready;
    // A load wins over a coincident tick; the prescaler is cleared instead.
    assign rot_en      = tick && !load_accept;

    rot_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load_accept),
        .tick (tick)
    );

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
        assign rot_left[gi]  = out_reg[(gi + WIDTH - 1) % WIDTH];
        assign rot_right[gi] = out_reg[(gi + 1) % WIDTH];
    end

`ifdef PARAM_ROTATOR_BOUNCE_EN
    // In bounce mode the stored direction flips when the lit end bit is set.
    always_comb begin
        eff_dir = dir_e'(dir);
        if (bounce) begin
            eff_dir = dir_reg;
            if (dir_reg == DIR_LEFT && out_reg[WIDTH-1]) begin
                eff_dir = DIR_RIGHT;
            end else if (dir_reg == DIR_RIGHT && out_reg[0]) begin
                eff_dir = DIR_LEFT;
            end
        end
    end
`else
    assign eff_dir = dir_e'(dir);
`endif

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        dir_next   = dir_reg;
        step_next  = 1'b0;

        case (state_reg)
            READY:   if (load_accept) state_next = BUSY;
            BUSY:    state_next = READY;
            default: state_next = READY;
        endcase

        if (load_accept) begin
            out_next = load_data;
            dir_next = dir_e'(dir);
        end else if (rot_en) begin
            out_next  = (eff_dir == DIR_LEFT) ? rot_left : rot_right;
            dir_next  = eff_dir;
            step_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= READY;
            out_reg   <= INIT;
            dir_reg   <= DIR_LEFT;
            step_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            dir_reg   <= dir_next;
            step_reg  <= step_next;
        end
    end

    assign out  = out_reg;
    assign step = step_reg;

endmodule

// File: tb/tb_param_rotator.sv
// Bench for param_rotator: three instances (W4/D1, W4/D3, W8/D1) checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_param_rotator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  en_s;
    logic [2:0]  dir_s;
    logic [2:0]  lv_s;
    logic [63:0] ld_s [3];
`ifdef PARAM_ROTATOR_BOUNCE_EN
    logic [2:0]  bnc_s;
`endif

    logic [3:0]  out_a, out_b;
    logic [7:0]  out_c;
    logic [2:0]  step_w, lr_w;
    logic [63:0] out_w [3];

    int total = 0;
    int bad   = 0;
    bit mon   = 0;

    param_rotator #(.WIDTH(4), .DIV(1)) u_a (
        .clk(clk), .rst(rst), .en(en_s[0]), .dir(dir_s[0]),
        .load_valid(lv_s[0]), .load_data(ld_s[0][3:0]),
`ifdef PARAM_ROTATOR_BOUNCE_EN
        .bounce(bnc_s[0]),
`endif
        .load_ready(lr_w[0]), .out(out_a), .step(step_w[0])
    );

    param_rotator #(.WIDTH(4), .DIV(3)) u_b (
        .clk(clk), .rst(rst), .en(en_s[1]), .dir(dir_s[1]),
        .load_valid(lv_s[1]), .load_data(ld_s[1][3:0]),
`ifdef PARAM_ROTATOR_BOUNCE_EN
        .bounce(bnc_s[1]),
`endif
        .load_ready(lr_w[1]), .out(out_b), .step(step_w[1])
    );

    param_rotator #(.WIDTH(8), .DIV(1)) u_c (
        .clk(clk), .rst(rst), .en(en_s[2]), .dir(dir_s[2]),
        .load_valid(lv_s[2]), .load_data(ld_s[2][7:0]),
`ifdef PARAM_ROTATOR_BOUNCE_EN
        .bounce(bnc_s[2]),
`endif
        .load_ready(lr_w[2]), .out(out_c), .step(step_w[2])
    );

    always_comb begin
        out_w[0] = {60'd0, out_a};
        out_w[1] = {60'd0, out_b};
        out_w[2] = {56'd0, out_c};
    end

    // Behavioural model: ring value as an integer, rotation as shift-and-wrap arithmetic.
    int          wd_t [3] = '{4, 4, 8};
    int          dv_t [3] = '{1, 3, 1};
    logic [63:0] m_out  [3];
    int          m_cnt  [3];
    bit          m_dir  [3];
    bit          m_busy [3];
    bit          m_step [3];

    function automatic logic [63:0] rot(logic [63:0] v, int w, bit right);
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (!right) return ((v << 1) | (v >> (w - 1))) & mask;
        else        return ((v >> 1) | ((v & 64'd1) << (w - 1))) & mask;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit accept, tk, d;
            if (rst) begin
                m_out[i] = 64'd1; m_cnt[i] = 0; m_dir[i] = 0;
                m_busy[i] = 0; m_step[i] = 0;
            end else begin
                accept    = lv_s[i] && !m_busy[i];
                tk        = en_s[i] && (m_cnt[i] == dv_t[i] - 1);
                m_step[i] = 0;
                if (accept) begin
                    m_out[i]  = ld_s[i] & rot(64'hFFFF_FFFF_FFFF_FFFF, wd_t[i], 0);
                    m_cnt[i]  = 0;
                    m_dir[i]  = dir_s[i];
                    m_busy[i] = 1;
                end else begin
                    m_busy[i] = 0;
                    if (tk) begin
                        d = dir_s[i];
`ifdef PARAM_ROTATOR_BOUNCE_EN
                        if (bnc_s[i]) begin
                            d = m_dir[i];
                            if (!d && m_out[i][wd_t[i]-1]) d = 1;
                            else if (d && m_out[i][0]) d = 0;
                        end
`endif
                        m_dir[i]  = d;
                        m_out[i]  = rot(m_out[i], wd_t[i], d);
                        m_cnt[i]  = 0;
                        m_step[i] = 1;
                    end else if (en_s[i]) begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
        $display("txn %s = %h", nm, act);
        chk(nm, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.out", i), out_w[i], m_out[i]);
                chk($sformatf("u%0d.step", i), 64'(step_w[i]), 64'(m_step[i]));
                chk($sformatf("u%0d.load_ready", i), 64'(lr_w[i]),
                    64'(!m_busy[i] && !rst));
            end
        end
    end

    task automatic adv(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] seq_a [4];
        logic [3:0] seq_bn [7];
        seq_a  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_bn = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        rst = 1; en_s = '0; dir_s = '0; lv_s = '0;
        for (int i = 0; i < 3; i++) ld_s[i] = '0;
`ifdef PARAM_ROTATOR_BOUNCE_EN
        bnc_s = '0;
`endif
        adv(1);
        mon = 1;
        adv(1);
        lit("a.out reset", out_a, 4'b0001);
        lit("a.load_ready reset", lr_w[0], 0);
        lit("a.step reset", step_w[0], 0);

        // W4 DIV1 left rotation every enabled edge
        rst = 0; en_s[0] = 1; dir_s[0] = 0;
        for (int k = 0; k < 4; k++) begin
            adv(1);
            lit("a.out rotl", out_a, seq_a[k]);
            lit("a.step rotl", step_w[0], 1);
        end
        dir_s[0] = 1; adv(1); lit("a.out dir right", out_a, 4'b1000);
        dir_s[0] = 0; adv(1); lit("a.out dir left", out_a, 4'b0001);
        en_s[0] = 0; adv(1);
        lit("a.step disabled", step_w[0], 0);
        lit("a.out disabled", out_a, 4'b0001);

        // all-zero pattern still steps
        lv_s[0] = 1; ld_s[0] = 64'h0; en_s[0] = 1; adv(1);
        lit("a.out load zero", out_a, 4'b0000);
        lv_s[0] = 0; adv(1);
        lit("a.step zero rot", step_w[0], 1);
        lit("a.out zero rot", out_a, 4'b0000);
        en_s[0] = 0;

        // W4 DIV3 right rotation, freeze while disabled
        lv_s[1] = 1; ld_s[1] = 64'h1; dir_s[1] = 1; en_s[1] = 1; adv(1);
        lit("b.out load", out_b, 4'b0001);
        lit("b.load_ready busy", lr_w[1], 0);
        lv_s[1] = 0; adv(2);
        lit("b.out pre-tick", out_b, 4'b0001);
        lit("b.step pre-tick", step_w[1], 0);
        adv(1);
        lit("b.out tick1", out_b, 4'b1000);
        lit("b.step tick1", step_w[1], 1);
        adv(1);
        en_s[1] = 0;
        for (int k = 0; k < 5; k++) begin
            adv(1);
            lit("b.out frozen", out_b, 4'b1000);
        end
        en_s[1] = 1; adv(1);
        lit("b.out resume", out_b, 4'b1000);
        adv(1);
        lit("b.out tick2", out_b, 4'b0100);
        lit("b.step tick2", step_w[1], 1);

        // load coincident with tick
        adv(2);
        lv_s[1] = 1; ld_s[1] = 64'hA; adv(1);
        lit("b.out load on tick", out_b, 4'b1010);
        lit("b.step load on tick", step_w[1], 0);
        lit("b.load_ready after load", lr_w[1], 0);
        lv_s[1] = 0; adv(1);
        lit("b.load_ready ready again", lr_w[1], 1);
        adv(1);
        lit("b.out hold after load", out_b, 4'b1010);
        adv(1);
        lit("b.out rot after load", out_b, 4'b0101);
        lit("b.step rot after load", step_w[1], 1);

        // reset mid-count and in BUSY
        adv(1);
        rst = 1; adv(1);
        lit("b.out rst midcount", out_b, 4'b0001);
        lit("b.step rst midcount", step_w[1], 0);
        adv(1);
        lit("b.load_ready rst held", lr_w[1], 0);
        rst = 0; #1;
        lit("b.load_ready rst released", lr_w[1], 1);
        lv_s[1] = 1; ld_s[1] = 64'h6; adv(1);
        lit("b.out busy load", out_b, 4'b0110);
        rst = 1; lv_s[1] = 0; adv(1);
        lit("b.out rst busy", out_b, 4'b0001);
        lit("b.load_ready rst busy", lr_w[1], 0);
        rst = 0; adv(2);
        lit("b.out post-rst count", out_b, 4'b0001);
        adv(1);
        lit("b.out post-rst tick", out_b, 4'b1000);
        lit("b.step post-rst tick", step_w[1], 1);
        en_s[1] = 0;

        // W8 wrap and all-ones
        lv_s[2] = 1; ld_s[2] = 64'h80; dir_s[2] = 0; en_s[2] = 1; adv(1);
        lit("c.out load 80", out_c, 8'h80);
        lv_s[2] = 0; adv(1);
        lit("c.out wrap", out_c, 8'h01);
        lit("c.step wrap", step_w[2], 1);
        lv_s[2] = 1; ld_s[2] = 64'hFF; adv(1);
        lit("c.out load ff", out_c, 8'hFF);
        lv_s[2] = 0; adv(1);
        lit("c.out ff rotl", out_c, 8'hFF);
        lit("c.step ff rotl", step_w[2], 1);
        dir_s[2] = 1; adv(1);
        lit("c.out ff rotr", out_c, 8'hFF);
        lit("c.step ff rotr", step_w[2], 1);
        en_s[2] = 0;

`ifdef PARAM_ROTATOR_BOUNCE_EN
        bnc_s[0] = 1; lv_s[0] = 1; ld_s[0] = 64'h1; dir_s[0] = 0; en_s[0] = 1; adv(1);
        lit("a.out bounce load", out_a, 4'b0001);
        lv_s[0] = 0; dir_s[0] = 1;
        for (int k = 0; k < 7; k++) begin
            adv(1);
            lit("a.out bounce", out_a, seq_bn[k]);
        end
        en_s[0] = 0;
`endif

        adv(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_rotator.md
PARAM_ROTATOR -- requirements
Module: param_rotator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, ring width in bits, 2..64.
REQ-002 SHALL have parameter DIV, default 1, clock cycles per rotation step, 1..65535.
REQ-003 SHALL have parameter INIT, default 1 (WIDTH bits), the pattern loaded on reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port en, input, 1, which enables prescaler counting and rotation.
REQ-007 SHALL have port dir, input, 1: 0 = rotate left (toward MSB), 1 = rotate right.
REQ-008 SHALL have port load_valid, input, 1, which requests a pattern load.
REQ-009 SHALL have port load_data, input, WIDTH, the pattern to load.
REQ-010 SHALL have port load_ready, output, 1, high when a load can be accepted.
REQ-011 SHALL have port out, output, WIDTH, the registered ring contents.
REQ-012 SHALL have port step, output, 1, a one-cycle pulse in the cycle out takes a rotated value.

Function
REQ-013 SHALL keep prescaler cnt (16 bits); tick = en && (cnt == DIV-1).
REQ-014 SHALL, on tick, rotate out by one position in the active direction, set cnt to 0, and assert step for that cycle.
REQ-015 SHALL, when en=1 and no tick, increment cnt by 1; when en=0, hold cnt, out and direction, with step=0.
REQ-016 SHALL, with DIV=1, rotate every enabled cycle (cnt stays 0).
REQ-017 SHALL wrap bits end-around: left moves out[WIDTH-1] to out[0]; right moves out[0] to out[WIDTH-1].
REQ-018 SHALL accept a load when load_valid && load_ready: out <= load_data, cnt <= 0, step=0, direction <= dir.
REQ-019 SHALL give a load priority over a coincident tick; no rotation occurs that cycle.
REQ-020 SHALL use states READY and BUSY: READY->BUSY on an accepted load, BUSY->READY after exactly one cycle; load_ready=1 only in READY.
REQ-021 SHALL, in BUSY, count and rotate normally if en=1 and ignore load_valid.
REQ-022 SHALL sample dir on every tick when bounce is inactive; a dir change takes effect on the next tick.
REQ-023 SHALL rotate an all-zero or all-one pattern without error (unchanged value, step still pulses).

Reset
REQ-024 SHALL, when rst=1 at a clk edge: out=INIT, cnt=0, step=0, state=READY, direction=left; load_ready=0 while rst is high.
REQ-025 SHALL let rst override load, tick and en in the same cycle, including mid-count and in BUSY.
REQ-026 SHALL begin counting on the first enabled edge after rst deasserts; first tick after DIV enabled cycles.

Configuration
REQ-027 SHALL provide macro PARAM_ROTATOR_BOUNCE_EN; when defined, adds input port bounce (1 bit) and a bounce direction FSM.
REQ-028 SHALL, with bounce=1 on a tick: if direction is left and out[WIDTH-1]=1, switch to right before rotating; if direction is right and out[0]=1, switch to left before rotating.
REQ-029 SHALL, with bounce=1, ignore dir except on load.
REQ-030 SHALL, without PARAM_ROTATOR_BOUNCE_EN, omit the bounce port and logic; behaviour is REQ-013..REQ-026 only.

Structure
REQ-031 SHALL place the direction encodings (DIR_LEFT=0, DIR_RIGHT=1) and the READY/BUSY state encoding in package rotator_pkg.
REQ-032 SHALL implement the prescaler as sub-module rot_prescaler (inputs clk, rst, en, clr; output tick; parameter DIV).

Verification
REQ-033 SHALL cover: WIDTH=4, DIV=1, en=1, dir=0 after reset -> out 0001,0010,0100,1000,0001 on successive edges, step high each cycle.
REQ-034 SHALL cover: DIV=3, dir=1, out=0001 -> 1000 after 3 enabled cycles, then 0100 after 3 more; step pulses exactly once per 3 cycles; en=0 for 5 cycles freezes out and cnt.
REQ-035 SHALL cover: load_data=1010 presented together with a tick -> out=1010, no step, load_ready=0 for one cycle, next rotation after DIV cycles.
REQ-036 SHALL cover: rst=1 mid-count (cnt=1, DIV=3) and in BUSY -> next cycle out=0001, cnt=0, step=0, load_ready=0 until rst falls.
REQ-037 SHALL cover, with PARAM_ROTATOR_BOUNCE_EN and bounce=1: WIDTH=4, DIV=1 from 0001 -> 0010,0100,1000,0100,0010,0001,0010.
REQ-038 SHALL cover: WIDTH=8, out=10000000, dir=0 -> 00000001; load 11111111 -> rotations keep 11111111 with step pulsing.
